// File: rtl/console_cell_shader_if.sv
// Cell load / pixel stream bundle for console_cell_shader.
// cursor_cell exists only when CONSOLE_CURSOR_EN is defined.
interface console_cell_shader_if #(
   parameter int CELL_WIDTH = 8
);
   logic                  frame_start;
   logic                  load;
   logic [CELL_WIDTH-1:0] glyph_row;
   logic [23:0]           fgrgb;
   logic [23:0]           bgrgb;
   logic                  blink;
`ifdef CONSOLE_CURSOR_EN
   logic                  cursor_cell;
`endif
   logic [23:0]           rgb;
   logic                  rgb_valid;
   logic                  blink_phase;

`ifdef CONSOLE_CURSOR_EN
   modport master (
      output frame_start, load, glyph_row, fgrgb, bgrgb, blink, cursor_cell,
      input  rgb, rgb_valid, blink_phase
   );
   modport slave (
      input  frame_start, load, glyph_row, fgrgb, bgrgb, blink, cursor_cell,
      output rgb, rgb_valid, blink_phase
   );
`else
   modport master (
      output frame_start, load, glyph_row, fgrgb, bgrgb, blink,
      input  rgb, rgb_valid, blink_phase
   );
   modport slave (
      input  frame_start, load, glyph_row, fgrgb, bgrgb, blink,
      output rgb, rgb_valid, blink_phase
   );
`endif
endinterface

// File: rtl/console_cell_shader.sv
// Character-cell pixel serializer with frame-based blink timer.
// Optional inverse-video cursor is enabled by defining CONSOLE_CURSOR_EN.
module console_cell_shader #(
   parameter int CELL_WIDTH   = 8,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                   clk_pixel,
   input  logic                   reset,
   console_cell_shader_if.slave   bus
);
   localparam int CNT_W = $clog2(CELL_WIDTH + 1);
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CELL_WIDTH - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

   logic [CELL_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [23:0]           fg_q, fg_d;
   logic [23:0]           bg_q, bg_d;
   logic [23:0]           rgb_q, rgb_d;
   logic                  valid_q, valid_d;
   logic [FRM_W-1:0]      frame_q, frame_d;
   logic                  phase_q, phase_d;

   logic [23:0]           fg_sub_s;
   logic [23:0]           fg_eff_s;
   logic [23:0]           bg_eff_s;

   // Colour resolution at load: blink substitution first, then cursor swap.
   always_comb begin
      fg_sub_s = bus.fgrgb;
      if (bus.blink && phase_q) begin
         fg_sub_s = bus.bgrgb;
      end else begin
         fg_sub_s = bus.fgrgb;
      end
`ifdef CONSOLE_CURSOR_EN
      if (bus.cursor_cell && !phase_q) begin
         fg_eff_s = bus.bgrgb;
         bg_eff_s = fg_sub_s;
      end else begin
         fg_eff_s = fg_sub_s;
         bg_eff_s = bus.bgrgb;
      end
`else
      fg_eff_s = fg_sub_s;
      bg_eff_s = bus.bgrgb;
`endif
   end

   // Pixel serializer: a load always restarts the cell, dropping any old pixels.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      fg_d    = fg_q;
      bg_d    = bg_q;
      rgb_d   = 24'h000000;
      valid_d = 1'b0;
      if (bus.load) begin
         shift_d = {bus.glyph_row[CELL_WIDTH-2:0], 1'b0};
         cnt_d   = CNT_FULL;
         fg_d    = fg_eff_s;
         bg_d    = bg_eff_s;
         rgb_d   = bus.glyph_row[CELL_WIDTH-1] ? fg_eff_s : bg_eff_s;
         valid_d = 1'b1;
      end else if (cnt_q != {CNT_W{1'b0}}) begin
         shift_d = {shift_q[CELL_WIDTH-2:0], 1'b0};
         cnt_d   = cnt_q - CNT_W'(1);
         rgb_d   = shift_q[CELL_WIDTH-1] ? fg_q : bg_q;
         valid_d = 1'b1;
      end else begin
         rgb_d   = 24'h000000;
         valid_d = 1'b0;
      end
   end

   // Blink timer: phase toggles on the frame_start that wraps the count.
   always_comb begin
      frame_d = frame_q;
      phase_d = phase_q;
      if (bus.frame_start) begin
         if (frame_q == FRM_LAST) begin
            frame_d = {FRM_W{1'b0}};
            phase_d = ~phase_q;
         end else begin
            frame_d = frame_q + FRM_W'(1);
         end
      end else begin
         frame_d = frame_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         shift_q <= {CELL_WIDTH{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         fg_q    <= 24'h000000;
         bg_q    <= 24'h000000;
         rgb_q   <= 24'h000000;
         valid_q <= 1'b0;
         frame_q <= {FRM_W{1'b0}};
         phase_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         fg_q    <= fg_d;
         bg_q    <= bg_d;
         rgb_q   <= rgb_d;
         valid_q <= valid_d;
         frame_q <= frame_d;
         phase_q <= phase_d;
      end
   end

   assign bus.rgb         = rgb_q;
   assign bus.rgb_valid   = valid_q;
   assign bus.blink_phase = phase_q;

endmodule
